// File: rtl/bus_arb_pkg.sv
// Shared state encoding and width defaults for the two-master bus arbiter.
// Combinational constants only; no latency, no backpressure.
// Hold counter width covers HOLD_MAX up to 255.
package bus_arb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } arb_state_t;

   localparam int DEF_AW     = 16;
   localparam int DEF_DW     = 64;
   localparam int HOLD_CNT_W = 8;
endpackage

// File: rtl/bus_arb_mux.sv
// Routes the owning master onto the BUS master port and returns bus_din to it.
// Purely combinational (zero latency); no backpressure, owner vector selects.
// With no owner every bus-side and return output is driven to zero.
module bus_arb_mux
   import bus_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic [1:0]    owner,
   input  logic          m0_req,
   input  logic          m0_wr,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_dout,
   input  logic          m1_req,
   input  logic          m1_wr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_dout,
   input  logic [DW-1:0] bus_din,
   output logic          bus_req,
   output logic          bus_wr,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_dout,
   output logic [DW-1:0] m0_din,
   output logic [DW-1:0] m1_din
);
   always_comb begin
      bus_req  = 1'b0;
      bus_wr   = 1'b0;
      bus_addr = '0;
      bus_dout = '0;
      m0_din   = '0;
      m1_din   = '0;
      if (owner[0]) begin
         bus_req  = m0_req;
         bus_wr   = m0_wr;
         bus_addr = m0_addr;
         bus_dout = m0_dout;
         m0_din   = bus_din;
      end else if (owner[1]) begin
         bus_req  = m1_req;
         bus_wr   = m1_wr;
         bus_addr = m1_addr;
         bus_dout = m1_dout;
         m1_din   = bus_din;
      end
   end
endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter sharing one BUS master port between CPU (m0) and DMA (m1).
// Grant registered one cycle after req; handoff between masters has no idle gap.
// ARB_HOLD_LIMIT_EN: owner is preempted after HOLD_MAX cycles if the other requests.
module bus_arbiter2
   import bus_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int HOLD_MAX = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_wr,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_dout,
   output logic          m0_grant,
   output logic [DW-1:0] m0_din,
   input  logic          m1_req,
   input  logic          m1_wr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_dout,
   output logic          m1_grant,
   output logic [DW-1:0] m1_din,
   output logic          bus_req,
   output logic          bus_wr,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_dout,
   input  logic          bus_grant,
   input  logic [DW-1:0] bus_din
);
   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("bus_arbiter2: HOLD_MAX must be in 2..255");
   end

   arb_state_t state, next_state;
   logic       last_owner;
   logic       at_limit;
   logic [1:0] owner;

`ifdef ARB_HOLD_LIMIT_EN
   logic [HOLD_CNT_W-1:0] hold_cnt;

   assign at_limit = (hold_cnt == HOLD_CNT_W'(HOLD_MAX - 1));

   // Saturates at the limit so a later request from the other master still preempts.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (next_state != state && next_state != IDLE) begin
         hold_cnt <= '0;
      end else if (state != IDLE && !at_limit) begin
         hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
      end
   end
`else
   assign at_limit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state <= next_state;
         if (next_state == G0) begin
            last_owner <= 1'b0;
         end else if (next_state == G1) begin
            last_owner <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) next_state = last_owner ? G0 : G1;
            else if (m0_req)      next_state = G0;
            else if (m1_req)      next_state = G1;
         end
         G0: begin
            if (!m0_req)               next_state = m1_req ? G1 : IDLE;
            else if (at_limit && m1_req) next_state = G1;
         end
         G1: begin
            if (!m1_req)               next_state = m0_req ? G0 : IDLE;
            else if (at_limit && m0_req) next_state = G0;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      owner    = {state == G1, state == G0};
      m0_grant = owner[0];
      m1_grant = owner[1];
   end

   bus_arb_mux #(.AW(AW), .DW(DW)) u_mux (
      .owner    (owner),
      .m0_req   (m0_req),
      .m0_wr    (m0_wr),
      .m0_addr  (m0_addr),
      .m0_dout  (m0_dout),
      .m1_req   (m1_req),
      .m1_wr    (m1_wr),
      .m1_addr  (m1_addr),
      .m1_dout  (m1_dout),
      .bus_din  (bus_din),
      .bus_req  (bus_req),
      .bus_wr   (bus_wr),
      .bus_addr (bus_addr),
      .bus_dout (bus_dout),
      .m0_din   (m0_din),
      .m1_din   (m1_din)
   );

   // The BUS may only grant a request we actually forwarded.
   a_no_bus_grant_in_idle: assert property (@(posedge clk) disable iff (reset)
      (state == IDLE) |-> !$rose(bus_grant));
endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: vector table, fairness/hold sequences, random vs model.
module tb_bus_arbiter2;
   localparam int AW   = 16;
   localparam int DW   = 64;
   localparam int HOLD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req, m0_wr, m1_req, m1_wr;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_dout, m1_dout;
   logic          m0_grant, m1_grant;
   logic [DW-1:0] m0_din, m1_din;
   logic          bus_req, bus_wr, bus_grant;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_dout, bus_din;

   assign bus_grant = bus_req;

   bus_arbiter2 #(.AW(AW), .DW(DW), .HOLD_MAX(HOLD)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m0_grant(m0_grant), .m0_din(m0_din),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
      .m1_grant(m1_grant), .m1_din(m1_din),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_dout(bus_dout),
      .bus_grant(bus_grant), .bus_din(bus_din)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: owner is -1 (nobody), 0 or 1; held counts cycles of the current tenure.
   int own  = -1;
   int last = 1;
   int held = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_step();
      int  nxt;
      bit  r[2];
      r[0] = m0_req;
      r[1] = m1_req;
      if (reset) begin
         own = -1; last = 1; held = 0;
         return;
      end
      if (own < 0) begin
         if (r[0] && r[1]) nxt = 1 - last;
         else if (r[0])    nxt = 0;
         else if (r[1])    nxt = 1;
         else              nxt = -1;
      end else if (!r[own]) begin
         nxt = r[1-own] ? 1 - own : -1;
      end else begin
         nxt = own;
`ifdef ARB_HOLD_LIMIT_EN
         if (r[1-own] && held >= HOLD) nxt = 1 - own;
`endif
      end
      if (nxt >= 0 && nxt != own) begin
         last = nxt;
         held = 1;
      end else if (nxt >= 0) begin
         held++;
      end
      own = nxt;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string tag);
      logic          e_req, e_wr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_dout, e_d0, e_d1;
      e_req = 0; e_wr = 0; e_addr = '0; e_dout = '0; e_d0 = '0; e_d1 = '0;
      if (own == 0) begin
         e_req = m0_req; e_wr = m0_wr; e_addr = m0_addr; e_dout = m0_dout; e_d0 = bus_din;
      end else if (own == 1) begin
         e_req = m1_req; e_wr = m1_wr; e_addr = m1_addr; e_dout = m1_dout; e_d1 = bus_din;
      end
      check({tag, " m0_grant"}, 64'(m0_grant), 64'(own == 0));
      check({tag, " m1_grant"}, 64'(m1_grant), 64'(own == 1));
      check({tag, " bus_req"},  64'(bus_req),  64'(e_req));
      check({tag, " bus_wr"},   64'(bus_wr),   64'(e_wr));
      check({tag, " bus_addr"}, 64'(bus_addr), 64'(e_addr));
      check({tag, " bus_dout"}, bus_dout, e_dout);
      check({tag, " m0_din"},   m0_din, e_d0);
      check({tag, " m1_din"},   m1_din, e_d1);
   endtask

   typedef struct {
      logic          rst, r0, r1, w0, w1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1, bdin;
      logic          eg0, eg1, ereq, ewr;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] edout, ed0, ed1;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int run;
      bit counting;
      bit m1_after;

      // rst r0 r1 w0 w1  a0 a1  d0 d1 bdin | g0 g1 req wr addr dout din0 din1
      vecs[0]  = '{1,1,1,0,0, 16'h0000,16'h1111, 64'h0,64'h0,64'haaaa,    0,0,0,0,16'h0000,64'h0,64'h0,64'h0};
      vecs[1]  = '{1,1,1,0,0, 16'h0000,16'h1111, 64'h0,64'h0,64'haaaa,    0,0,0,0,16'h0000,64'h0,64'h0,64'h0};
      vecs[2]  = '{0,1,1,0,0, 16'h0000,16'h1111, 64'h0,64'h0,64'haaaa,    1,0,1,0,16'h0000,64'h0,64'haaaa,64'h0};
      vecs[3]  = '{0,0,1,0,1, 16'h0000,16'h7030, 64'h0,64'hf0f0,64'h1234, 0,1,1,1,16'h7030,64'hf0f0,64'h0,64'h1234};
      vecs[4]  = '{0,0,0,0,1, 16'h0000,16'h7030, 64'h0,64'hf0f0,64'h5555, 0,0,0,0,16'h0000,64'h0,64'h0,64'h0};
      vecs[5]  = '{0,0,1,0,1, 16'h0000,16'h7030, 64'h0,64'hf0f0,64'h5555, 0,1,1,1,16'h7030,64'hf0f0,64'h0,64'h5555};
      vecs[6]  = '{0,0,0,0,0, 16'h0000,16'h0000, 64'h0,64'h0,64'h5555,    0,0,0,0,16'h0000,64'h0,64'h0,64'h0};
      vecs[7]  = '{0,1,0,0,0, 16'h07ff,16'h0000, 64'h0,64'h0,64'h0f0f,    1,0,1,0,16'h07ff,64'h0,64'h0f0f,64'h0};
      vecs[8]  = '{0,1,1,0,1, 16'h07ff,16'h2222, 64'h0,64'h9,64'h0f0f,    1,0,1,0,16'h07ff,64'h0,64'h0f0f,64'h0};
      vecs[9]  = '{1,1,1,0,1, 16'h07ff,16'h2222, 64'h0,64'h9,64'h0f0f,    0,0,0,0,16'h0000,64'h0,64'h0,64'h0};
      vecs[10] = '{0,1,1,0,0, 16'h0abc,16'h0def, 64'h3,64'h4,64'h77,      1,0,1,0,16'h0abc,64'h3,64'h77,64'h0};

      reset = 1; m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
      m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0; bus_din = '0;
      #1;

      for (int i = 0; i < 11; i++) begin
         reset = vecs[i].rst; m0_req = vecs[i].r0; m1_req = vecs[i].r1;
         m0_wr = vecs[i].w0; m1_wr = vecs[i].w1;
         m0_addr = vecs[i].a0; m1_addr = vecs[i].a1;
         m0_dout = vecs[i].d0; m1_dout = vecs[i].d1; bus_din = vecs[i].bdin;
         tick();
         check($sformatf("vec%0d m0_grant", i), 64'(m0_grant), 64'(vecs[i].eg0));
         check($sformatf("vec%0d m1_grant", i), 64'(m1_grant), 64'(vecs[i].eg1));
         check($sformatf("vec%0d bus_req", i),  64'(bus_req),  64'(vecs[i].ereq));
         check($sformatf("vec%0d bus_wr", i),   64'(bus_wr),   64'(vecs[i].ewr));
         check($sformatf("vec%0d bus_addr", i), 64'(bus_addr), 64'(vecs[i].eaddr));
         check($sformatf("vec%0d bus_dout", i), bus_dout, vecs[i].edout);
         check($sformatf("vec%0d m0_din", i),   m0_din, vecs[i].ed0);
         check($sformatf("vec%0d m1_din", i),   m1_din, vecs[i].ed1);
      end

      // Fairness: master 0 owns; each owner releases for one cycle, grants must alternate.
      for (int k = 0; k < 6; k++) begin
         int exp_owner;
         exp_owner = (k % 2 == 0) ? 1 : 0;
         m0_req = (exp_owner == 0);
         m1_req = (exp_owner == 1);
         tick();
         check($sformatf("fair%0d m0_grant", k), 64'(m0_grant), 64'(exp_owner == 0));
         check($sformatf("fair%0d m1_grant", k), 64'(m1_grant), 64'(exp_owner == 1));
      end

      // Hold limit: both requesters hold req continuously from reset.
      reset = 1; m0_req = 1; m1_req = 1;
      tick();
      reset = 0;
      run = 0; counting = 1; m1_after = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (counting && m0_grant) run++;
         else counting = 0;
         if (c == HOLD) m1_after = m1_grant;
      end
`ifdef ARB_HOLD_LIMIT_EN
      check("hold m0 run", 64'(run), 64'(HOLD));
      check("hold m1 takes over", 64'(m1_after), 64'd1);
`else
      check("hold m0 run", 64'(run), 64'd12);
      check("hold m1 never granted", 64'(m1_after), 64'd0);
`endif

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         reset   = ($urandom_range(0, 31) == 0);
         m0_req  = 1'($urandom_range(0, 1));
         m1_req  = 1'($urandom_range(0, 1));
         m0_wr   = 1'($urandom_range(0, 1));
         m1_wr   = 1'($urandom_range(0, 1));
         m0_addr = AW'($urandom);
         m1_addr = AW'($urandom);
         m0_dout = {$urandom, $urandom};
         m1_dout = {$urandom, $urandom};
         bus_din = {$urandom, $urandom};
         tick();
         check_model($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-master arbiter in front of the single-master BUS block; shares its master port (req/wr/addr/dout/grant/din) between master 0 (CPU) and master 1 (DMA).
- Registered round-robin grant state machine, with an address/data mux into the BUS master port and a read-data return path to the granted master.
- Optional hold-limit counter forces rotation when one master hogs the bus.

Parameters:
- AW, 16, address width (matches BUS m_addr)
- DW, 64, data width (matches BUS m_dout/m_din)
- HOLD_MAX, 8, max consecutive grant cycles before forced rotation (used only with ARB_HOLD_LIMIT_EN; legal 2..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 bus request
- m0_wr  in  1  master 0 write (1) / read (0)
- m0_addr  in  AW  master 0 address
- m0_dout  in  DW  master 0 write data
- m0_grant  out  1  master 0 owns bus
- m0_din  out  DW  read data to master 0
- m1_req, m1_wr, m1_addr, m1_dout, m1_grant, m1_din: same as master 0, for master 1
- bus_req  out  1  to BUS m_req
- bus_wr  out  1  to BUS m_wr
- bus_addr  out  AW  to BUS m_addr
- bus_dout  out  DW  to BUS m_dout
- bus_grant  in  1  from BUS m_grant
- bus_din  in  DW  from BUS m_din

Behaviour:
- One clock; reset is synchronous and active-high.
- States: IDLE, G0 (master 0 owns), G1 (master 1 owns). Grant outputs are registered: m0_grant=(state==G0), m1_grant=(state==G1).
- Reset: state=IDLE, last_owner=1 (so master 0 wins the first tie), hold_cnt=0. All outputs 0 in the cycle after reset is sampled high.
- IDLE:
  - only m0_req -> G0; only m1_req -> G1; none -> stay.
  - both -> the master other than last_owner.
  - Grant appears 1 cycle after req is sampled.
- G0 with m0_req=1 -> stay in G0, unless the hold limit applies (see Optional Feature).
- G0 with m0_req=0: m1_req=1 -> G1 directly (no dead cycle); else -> IDLE.
- G1 is symmetric to G0.
- last_owner updates on every entry to G0/G1.
- Mux in G0:
  - bus_req=m0_req, bus_wr=m0_wr, bus_addr=m0_addr, bus_dout=m0_dout.
  - m0_din=bus_din, m1_din=0.
- Mux in G1: symmetric.
- Mux in IDLE: bus_req=0, bus_wr=0, bus_addr=0, bus_dout=0, m0_din=m1_din=0. The mux is combinational from state.
- bus_grant is not used for arbitration; it is exposed only for a per-master assertion that bus_grant never rises while in IDLE.
- Reset mid-grant: next edge forces IDLE, drops grant, zeroes the bus_* outputs; any transfer in progress is abandoned.
- Requester rule: a master must hold req, addr, wr and dout stable until it sees its grant. A req dropped before grant is simply not served.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - 8-bit hold_cnt clears on each grant entry and increments each cycle in G0/G1.
  - When hold_cnt==HOLD_MAX-1 and the other master requests, switch to it on the next edge even if the owner still requests; the preempted master sees its grant drop.
  - If the other master is not requesting, hold_cnt saturates and the owner keeps the bus.
- Undefined: no counter; the owner keeps the bus until it drops req.

Decomposition:
- Package bus_arb_pkg:
  - state encodings IDLE=2'b00, G0=2'b01, G1=2'b10
  - default AW/DW constants
  - HOLD_CNT_W=8
- Sub-module bus_arb_mux: purely combinational master-to-bus and bus_din return mux, driven by a 2-bit one-hot owner vector.
- FSM and counter stay in bus_arbiter2.

Test Plan:
- Reset: reset=1 for 2 cycles with m0_req=m1_req=1 -> all grants and bus_* are 0. After release, m0_grant=1 next cycle (last_owner=1 at reset) and bus_addr=m0_addr=16'h0000.
- Single master: m1_req=1, m1_addr=16'h7030, m1_wr=1, m1_dout=64'hf0f0 -> next cycle m1_grant=1, bus_addr=16'h7030, bus_wr=1, bus_dout=64'hf0f0, m0_grant=0.
- Handoff with no gap: both request, master 0 owns. Drop m0_req -> next cycle m1_grant=1, m0_grant=0, no IDLE cycle. Drop m1_req with m0_req=0 -> IDLE, bus_req=0.
- Fairness: both request continuously and each releases req for one cycle after every grant -> grants alternate 0,1,0,1.
- Read return: master 0 granted reading 16'h07ff, bus_din=64'h0f0f -> m0_din=64'h0f0f, m1_din=0.
- Hold limit: with ARB_HOLD_LIMIT_EN and HOLD_MAX=4, both hold req -> m0_grant high exactly 4 cycles, then m1_grant. Without the macro -> m0_grant stays high indefinitely.
